axis_fifo_ctrl: RTL and testbench

Single-clock AXI-Stream FIFO controller that drives the write and read ports of the team's simple-dual-port block RAM.
- Upstream side: accepts an AXI-Stream slave, writes accepted beats into the RAM.
- Downstream side: prefetches RAM reads into a small output FIFO, hiding the RAM's 1- or 2-cycle read latency, and presents a fully pipelined AXI-Stream master.
- Together with the RAM it forms the axis_fifo; the RAM itself is instantiated alongside, not inside.

---
 rtl/axis_fifo_ctrl_if.sv | 62 ++++++
 rtl/axis_fifo_ctrl.sv | 125 ++++++++++++
 tb/tb_axis_fifo_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_fifo_ctrl_if.sv
// +------------------------------------------------------------------------+
// | axis_fifo_ctrl_if : stream and block-RAM port bundle for axis_fifo_ctrl |
// | Optional macro AXIS_FIFO_TLAST_EN adds tlast to both stream sides.     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

interface axis_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 512
);
    localparam int AW = $clog2(DEPTH);
`ifdef AXIS_FIFO_TLAST_EN
    localparam int RW = DATA_WIDTH + 1;
`else
    localparam int RW = DATA_WIDTH;
`endif

    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic [AW-1:0]         ram_addra;
    logic                  ram_wea;
    logic [RW-1:0]         ram_dina;
    logic [AW-1:0]         ram_addrb;
    logic                  ram_enb;
    logic                  ram_regceb;
    logic                  ram_rstb;
    logic [RW-1:0]         ram_doutb;
`ifdef AXIS_FIFO_TLAST_EN
    logic                  s_axis_tlast;
    logic                  m_axis_tlast;

    // master: the controller itself; slave: upstream/downstream/RAM around it
    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready, ram_doutb,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output ram_addra, ram_wea, ram_dina, ram_addrb, ram_enb, ram_regceb, ram_rstb
    );
    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready, ram_doutb,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  ram_addra, ram_wea, ram_dina, ram_addrb, ram_enb, ram_regceb, ram_rstb
    );
`else
    modport master (
        input  s_axis_tdata, s_axis_tvalid, m_axis_tready, ram_doutb,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid,
        output ram_addra, ram_wea, ram_dina, ram_addrb, ram_enb, ram_regceb, ram_rstb
    );
    modport slave (
        output s_axis_tdata, s_axis_tvalid, m_axis_tready, ram_doutb,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid,
        input  ram_addra, ram_wea, ram_dina, ram_addrb, ram_enb, ram_regceb, ram_rstb
    );
`endif
endinterface

`default_nettype wire

// File: rtl/axis_fifo_ctrl.sv
// +------------------------------------------------------------------------+
// | axis_fifo_ctrl : AXI-Stream FIFO controller for an external SDP RAM,   |
// | with read prefetch into a small output FIFO. Macro: AXIS_FIFO_TLAST_EN.|
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module axis_fifo_ctrl #(
    parameter int DATA_WIDTH   = 64,
    parameter int DEPTH        = 512,
    parameter int READ_LATENCY = 2,
    parameter int OUT_DEPTH    = 4
) (
    input  wire logic              clka,
    input  wire logic              rstb,
    axis_fifo_ctrl_if.master       bus,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
`ifdef AXIS_FIFO_TLAST_EN
    localparam int RW = DATA_WIDTH + 1;
`else
    localparam int RW = DATA_WIDTH;
`endif
    localparam int OW = $clog2(OUT_DEPTH + 1);
    localparam int PW = $clog2(OUT_DEPTH);
    localparam logic [AW:0] DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [OW:0] OUT_LIMIT = (OW+1)'(OUT_DEPTH);

    logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]             ram_count_q, ram_count_d, count_q, count_d;
    logic [READ_LATENCY-1:0] pipe_q, pipe_d;
    logic [OW-1:0]           inflight_q, inflight_d, ocount_q, ocount_d;
    logic [PW-1:0]           ohead_q, ohead_d, otail_q, otail_d;
    logic [RW-1:0]           omem_q [OUT_DEPTH];
    logic [RW-1:0]           head;
    logic                    wr, rd, push, pop;

    function automatic logic [PW-1:0] ring_next(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign bus.s_axis_tready = (ram_count_q != DEPTH_W);
    assign wr   = bus.s_axis_tvalid & bus.s_axis_tready;
    // Credit check: reserve an output slot for every read still in the RAM pipe
    assign rd   = (ram_count_q != '0) &&
                  (({1'b0, ocount_q} + {1'b0, inflight_q}) < OUT_LIMIT);
    assign push = pipe_q[READ_LATENCY-1];
    assign pop  = (ocount_q != '0) & bus.m_axis_tready;

    assign bus.ram_wea    = wr;
    assign bus.ram_addra  = wr_ptr_q;
    assign bus.ram_enb    = rd;
    assign bus.ram_addrb  = rd_ptr_q;
    assign bus.ram_regceb = 1'b1;
    assign bus.ram_rstb   = rstb;

    assign head              = omem_q[ohead_q];
    assign bus.m_axis_tvalid = (ocount_q != '0);
    assign count             = count_q;

`ifdef AXIS_FIFO_TLAST_EN
    assign bus.ram_dina     = {bus.s_axis_tlast, bus.s_axis_tdata};
    assign bus.m_axis_tdata = head[DATA_WIDTH-1:0];
    assign bus.m_axis_tlast = head[RW-1];
`else
    assign bus.ram_dina     = bus.s_axis_tdata;
    assign bus.m_axis_tdata = head;
`endif

    generate
        if (READ_LATENCY == 1) begin : g_pipe_lat1
            always_comb pipe_d = rd;
        end else begin : g_pipe_latn
            always_comb pipe_d = {pipe_q[READ_LATENCY-2:0], rd};
        end
    endgenerate

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ohead_d     = ohead_q;
        otail_d     = otail_q;
        if (wr)   wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd)   rd_ptr_d = rd_ptr_q + AW'(1);
        if (pop)  ohead_d  = ring_next(ohead_q);
        if (push) otail_d  = ring_next(otail_q);
        ram_count_d = ram_count_q + (AW+1)'(wr) - (AW+1)'(rd);
        inflight_d  = inflight_q + OW'(rd) - OW'(push);
        ocount_d    = ocount_q + OW'(push) - OW'(pop);
        // Summed from next-state terms so count tracks the registers it mirrors
        count_d     = ram_count_d + (AW+1)'(inflight_d) + (AW+1)'(ocount_d);
    end

    always_ff @(posedge clka) begin
        if (rstb) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_count_q <= '0;
            pipe_q      <= '0;
            inflight_q  <= '0;
            ocount_q    <= '0;
            ohead_q     <= '0;
            otail_q     <= '0;
            count_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_count_q <= ram_count_d;
            pipe_q      <= pipe_d;
            inflight_q  <= inflight_d;
            ocount_q    <= ocount_d;
            ohead_q     <= ohead_d;
            otail_q     <= otail_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clka) begin
        if (push) omem_q[otail_q] <= bus.ram_doutb;
    end

endmodule

`default_nettype wire

// File: tb/tb_axis_fifo_ctrl.sv
// +------------------------------------------------------------------------+
// | tb_axis_fifo_ctrl : directed bench for axis_fifo_ctrl with a RAM model.|
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_axis_fifo_ctrl;
    localparam int DW  = 16;
    localparam int DEP = 16;
    localparam int RL  = 2;
    localparam int OD  = 4;
    localparam int AW  = $clog2(DEP);
`ifdef AXIS_FIFO_TLAST_EN
    localparam int RW = DW + 1;
`else
    localparam int RW = DW;
`endif

    logic          clka = 1'b0;
    logic          rstb;
    logic [AW:0]   count;

    axis_fifo_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(DEP)) bus ();

    axis_fifo_ctrl #(
        .DATA_WIDTH(DW), .DEPTH(DEP), .READ_LATENCY(RL), .OUT_DEPTH(OD)
    ) dut (
        .clka (clka),
        .rstb (rstb),
        .bus  (bus),
        .count(count)
    );

    always #5 clka = ~clka;

    // Two-stage RAM: array read register, then output register
    logic [RW-1:0] mem [DEP];
    logic [RW-1:0] rd_reg;
    always @(posedge clka) begin
        if (bus.ram_wea) mem[bus.ram_addra] <= bus.ram_dina;
        if (bus.ram_enb) rd_reg <= mem[bus.ram_addrb];
        if (bus.ram_rstb)        bus.ram_doutb <= '0;
        else if (bus.ram_regceb) bus.ram_doutb <= rd_reg;
    end

    int total = 0;
    int bad   = 0;
    int wn    = 0;
    int pops  = 0;
    int lp0   = 0;
    int w0, p0, cyc, k, maxc;
    logic [31:0] lastmask = '0;
    logic [DW:0] q [$];
    logic [DW:0] exp_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic lst;
        #1;
`ifdef AXIS_FIFO_TLAST_EN
        lst = bus.s_axis_tlast;
`else
        lst = 1'b0;
`endif
        if (bus.s_axis_tvalid && bus.s_axis_tready) begin
            q.push_back({lst, bus.s_axis_tdata});
            wn++;
        end
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            if (q.size() == 0) begin
                chk("spurious_pop", 32'(bus.m_axis_tvalid), 32'd0);
            end else begin
                exp_e = q.pop_front();
                chk("pop_data", 32'(bus.m_axis_tdata), 32'(exp_e[DW-1:0]));
`ifdef AXIS_FIFO_TLAST_EN
                chk("pop_tlast", 32'(bus.m_axis_tlast), 32'(exp_e[DW]));
                if (bus.m_axis_tlast) lastmask = lastmask | (32'd1 << (pops - lp0 + 1));
`endif
            end
            pops++;
        end
        @(posedge clka);
        @(negedge clka);
        chk("count", 32'(count), 32'(q.size()));
    endtask

    initial begin
        rstb = 1'b1;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.m_axis_tready = 1'b0;
`ifdef AXIS_FIFO_TLAST_EN
        bus.s_axis_tlast  = 1'b0;
`endif
        // Reset held for two edges, then idle
        repeat (2) @(posedge clka);
        @(negedge clka);
        chk("rst_ram_rstb", 32'(bus.ram_rstb), 32'd1);
        rstb = 1'b0;
        #1;
        chk("rst_tready", 32'(bus.s_axis_tready), 32'd1);
        chk("rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        chk("rst_count",  32'(count), 32'd0);
        chk("rst_wea",    32'(bus.ram_wea), 32'd0);
        chk("rst_enb",    32'(bus.ram_enb), 32'd0);
        chk("regceb",     32'(bus.ram_regceb), 32'd1);

        // Single beat: visible three edges after the accepting edge
        @(negedge clka);
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = 16'h00A5;
        bus.m_axis_tready = 1'b1;
        #1;
        chk("single_wea", 32'(bus.ram_wea), 32'd1);
        tick();
        bus.s_axis_tvalid = 1'b0;
        chk("single_n1", 32'(bus.m_axis_tvalid), 32'd0);
        tick();
        chk("single_n2", 32'(bus.m_axis_tvalid), 32'd0);
        tick();
        chk("single_n3_early", 32'(bus.m_axis_tvalid), 32'd0);
        tick();
        chk("single_valid", 32'(bus.m_axis_tvalid), 32'd1);
        chk("single_data",  32'(bus.m_axis_tdata), 32'h00A5);
        tick();
        chk("single_empty", 32'(bus.m_axis_tvalid), 32'd0);
        chk("single_count0", 32'(count), 32'd0);

        // Fill: 16 in RAM + 4 prefetched, then back-pressure
        bus.m_axis_tready = 1'b0;
        w0 = wn;
        for (int i = 0; i < 30; i++) begin
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tdata  = DW'(wn - w0);
            tick();
        end
        bus.s_axis_tvalid = 1'b0;
        chk("fill_accepted", 32'(wn - w0), 32'd20);
        chk("fill_tready",   32'(bus.s_axis_tready), 32'd0);
        chk("fill_count",    32'(count), 32'd20);
        bus.m_axis_tready = 1'b1;
        tick();
        bus.m_axis_tready = 1'b0;
        k = 0;
        while (!bus.s_axis_tready && k < 2) begin
            tick();
            k++;
        end
        chk("fill_reopen", 32'(bus.s_axis_tready), 32'd1);
        cyc = 0;
        bus.m_axis_tready = 1'b1;
        while (((wn - w0) < 26 || q.size() != 0) && cyc < 200) begin
            bus.s_axis_tvalid = ((wn - w0) < 26);
            bus.s_axis_tdata  = DW'(wn - w0);
            tick();
            cyc++;
        end
        bus.s_axis_tvalid = 1'b0;
        chk("fill_drained", 32'(q.size()), 32'd0);

        // Streaming: one beat per cycle both ways
        w0 = wn; p0 = pops; cyc = 0;
        while ((pops - p0) < 1000 && cyc < 1200) begin
            bus.s_axis_tvalid = ((wn - w0) < 1000);
            bus.s_axis_tdata  = DW'(16'h1000 + (wn - w0));
            tick();
            cyc++;
        end
        bus.s_axis_tvalid = 1'b0;
        chk("stream_pops",   32'(pops - p0), 32'd1000);
        chk("stream_cycles", 32'(cyc), 32'd1004);

        // Random stalls on both sides
        w0 = wn; p0 = pops; cyc = 0; maxc = 0;
        while ((pops - p0) < 5000 && cyc < 40000) begin
            bus.s_axis_tvalid = ((wn - w0) < 5000) && ($urandom_range(0, 1) == 1);
            bus.s_axis_tdata  = DW'($urandom);
            bus.m_axis_tready = ($urandom_range(0, 1) == 1);
            tick();
            if (int'(count) > maxc) maxc = int'(count);
            cyc++;
        end
        bus.s_axis_tvalid = 1'b0;
        chk("rand_pops",  32'(pops - p0), 32'd5000);
        chk("rand_max",   32'(maxc <= DEP + OD), 32'd1);

        // Reset with 10 beats held: none may reappear
        bus.m_axis_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tdata  = DW'(16'hDE00 + i);
            tick();
        end
        bus.s_axis_tvalid = 1'b0;
        rstb = 1'b1;
        @(posedge clka);
        @(negedge clka);
        rstb = 1'b0;
        q.delete();
        #1;
        chk("mrst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        chk("mrst_count",  32'(count), 32'd0);
        chk("mrst_tready", 32'(bus.s_axis_tready), 32'd1);
        bus.m_axis_tready = 1'b1;
        repeat (5) tick();
        chk("mrst_quiet", 32'(bus.m_axis_tvalid), 32'd0);
        w0 = wn; cyc = 0;
        while (((wn - w0) < 3 || q.size() != 0) && cyc < 50) begin
            bus.s_axis_tvalid = ((wn - w0) < 3);
            bus.s_axis_tdata  = DW'(16'h0B00 + (wn - w0));
            tick();
            cyc++;
        end
        bus.s_axis_tvalid = 1'b0;
        chk("mrst_after", 32'(q.size()), 32'd0);

`ifdef AXIS_FIFO_TLAST_EN
        // Packets of 1, 3, 7 beats: tlast on beats 1, 4, 11
        w0 = wn; lp0 = pops; lastmask = '0; cyc = 0;
        while (((wn - w0) < 11 || q.size() != 0) && cyc < 100) begin
            k = wn - w0;
            bus.s_axis_tvalid = (k < 11);
            bus.s_axis_tdata  = DW'(16'h0C00 + k);
            bus.s_axis_tlast  = (k == 0) || (k == 3) || (k == 10);
            tick();
            cyc++;
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        chk("tlast_mask", lastmask, 32'h0000_0812);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
